// File: rtl/uart_host_pkg.sv
// Shared types and protocol constants for the uart2bus host-side initiator.
package uart_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GUARD,
    DRAIN,
    WAIT_RSP,
    RESP
  } state_t;

  localparam logic [7:0] BIN_PREFIX = 8'h00;
  localparam logic [7:0] CMD_WRITE  = 8'h20;
  localparam logic [7:0] CMD_READ   = 8'h10;
  localparam logic [7:0] ACK_BYTE   = 8'h5A;
  localparam logic [7:0] LEN_ONE    = 8'h01;

  // Byte at position idx of a single-byte binary command frame.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic        wr,
                                            input logic [15:0] addr,
                                            input logic [7:0]  wdata);
    case (idx)
      3'd0:    frame_byte = BIN_PREFIX;
      3'd1:    frame_byte = wr ? CMD_WRITE : CMD_READ;
      3'd2:    frame_byte = addr[15:8];
      3'd3:    frame_byte = addr[7:0];
      3'd4:    frame_byte = LEN_ONE;
      default: frame_byte = wdata;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_timeout.sv
// Response watchdog: counts cycles while enabled, flags the last allowed cycle.
module uart_host_timeout #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count;

  // Cycle counter, held at zero whenever cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 16'd1;
  end

  assign expire = enable && (count == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/uart_host_master.sv
// Host initiator for the uart2bus binary protocol: one request -> one frame
// on the uart_top tx byte port, then one response byte from the rx port.
// Optional feature macro: UART_HOST_TIMEOUT_EN (response watchdog).
module uart_host_master
  import uart_host_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_err,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data
);

  state_t      state, state_nxt;
  logic        rdy_q;
  logic [2:0]  idx;
  logic        lat_write;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        tmo_exp;
  logic [2:0]  last_idx;

  assign last_idx = lat_write ? 3'd5 : 3'd4;

`ifdef UART_HOST_TIMEOUT_EN
  uart_host_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != WAIT_RSP),
    .enable (state == WAIT_RSP),
    .expire (tmo_exp)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_exp        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and frame/response strobes.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    new_tx_data = 1'b0;
    tx_data     = '0;
    resp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = rdy_q;
        if (req_valid && rdy_q) state_nxt = SEND;
      end
      SEND: begin
        tx_data = frame_byte(idx, lat_write, lat_addr, lat_wdata);
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          state_nxt   = GUARD;
        end
      end
      // tx_busy lags the strobe by a cycle, so it is not trusted here.
      GUARD:    state_nxt = (idx == last_idx) ? DRAIN : SEND;
      DRAIN:    if (!tx_busy) state_nxt = WAIT_RSP;
      WAIT_RSP: if (new_rx_data || tmo_exp) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Request capture, byte index and response capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q     <= 1'b0;
      idx       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        IDLE: if (req_valid && rdy_q) begin
          lat_write <= req_write;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          idx       <= '0;
        end
        GUARD: if (idx != last_idx) idx <= idx + 3'd1;
        WAIT_RSP: begin
          // A byte on the expiry cycle takes priority over the timeout.
          if (new_rx_data) begin
            rdata_q <= lat_write ? 8'h00 : rx_data;
            err_q   <= lat_write && (rx_data != ACK_BYTE);
          end else if (tmo_exp) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = (state == RESP) ? rdata_q : 8'h00;
  assign resp_err   = (state == RESP) ? err_q   : 1'b0;

endmodule

// File: tb/tb_uart_host_master.sv
// Scoreboard bench for uart_host_master: expected tx bytes and responses are
// queued at stimulus time and checked as the DUT produces them.
module tb_uart_host_master;

  localparam logic [15:0] TMO       = 16'd20;
  localparam int          DRAIN_LAT = 5;  // last strobe -> first WAIT_RSP cycle with 3-cycle busy

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_err;
  logic [7:0]  resp_rdata;
  logic [7:0]  tx_data;
  logic        new_tx_data, tx_busy;
  logic [7:0]  rx_data;
  logic        new_rx_data;

  uart_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .new_rx_data(new_rx_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rsp[$];   // {err, rdata}
  int  n_resp      = 0;
  int  rsp_cyc_exp = 0;
  int  acc_cyc     = 0;
  int  last_strb   = 0;
  bit  first_pend  = 0;
  bit  strobe_q    = 0;
  int  busy_cnt    = 0;
  bit  busy_force  = 0;

  assign tx_busy = busy_force || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Transmitter model: busy for 3 cycles starting the cycle after a strobe.
  always @(posedge clock) begin
    #1;
    if (strobe_q)          busy_cnt = 3;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
  end

  // Output monitor.
  always @(negedge clock) begin
    strobe_q = new_tx_data;
    if (new_tx_data) begin
      chk("strb_busy", {31'd0, tx_busy}, 0);
      if (exp_tx.size() == 0) chk("tx_extra", 1, 0);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      if (first_pend) begin
        chk("acc2strb", cyc - acc_cyc, 1);
        first_pend = 0;
      end else begin
        chk("strb_gap", {31'd0, (cyc - last_strb) >= 2}, 1);
      end
      last_strb = cyc;
    end
    if (resp_valid) begin
      n_resp++;
      if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
      else chk("rsp", {23'd0, resp_err, resp_rdata}, {23'd0, exp_rsp.pop_front()});
      chk("rsp_cyc", cyc, rsp_cyc_exp);
    end
  end

  task automatic push_frame(input logic wr, input logic [15:0] a, input logic [7:0] d);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(wr ? 8'h20 : 8'h10);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back(8'h01);
    if (wr) exp_tx.push_back(d);
  endtask

  task automatic send_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
    int i;
    for (i = 0; i < 200 && !req_ready; i++) step(1);
    if (!req_ready) chk("ready_wait", 0, 1);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    acc_cyc = cyc; first_pend = 1;
    step(1);
    req_valid = 1'b0; req_write = ~wr; req_addr = 16'hFFFF; req_wdata = 8'hEE;
  endtask

  task automatic wait_tx_left(input int left);
    int i;
    for (i = 0; i < 2000 && exp_tx.size() > left; i++) step(1);
    if (exp_tx.size() > left) chk("tx_wait", exp_tx.size(), left);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; new_rx_data = 1'b1; rsp_cyc_exp = cyc + 1;
    step(1);
    new_rx_data = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_resp(input int n0);
    int i;
    for (i = 0; i < 2000 && n_resp == n0; i++) step(1);
    if (n_resp == n0) chk("rsp_wait", 0, 1);
  endtask

  task automatic txn(input logic wr, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] rsp_byte, input logic [8:0] exp);
    int n0;
    n0 = n_resp;
    push_frame(wr, a, d);
    exp_rsp.push_back(exp);
    send_req(wr, a, d);
    wait_tx_left(0);
    step(10);
    rx_pulse(rsp_byte);
    wait_resp(n0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rdy"},  {31'd0, req_ready},   0);
    chk({tag, "_strb"}, {31'd0, new_tx_data}, 0);
    chk({tag, "_txd"},  {24'd0, tx_data},     0);
    chk({tag, "_rv"},   {31'd0, resp_valid},  0);
    chk({tag, "_rd"},   {24'd0, resp_rdata},  0);
    chk({tag, "_err"},  {31'd0, resp_err},    0);
  endtask

  initial begin
    int n0;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rx_data = '0; new_rx_data = 1'b0;
    step(3);
    chk_idle_outs("rst");
    reset = 1'b1;
    step(1);
    chk("rdy_after_rst", {31'd0, req_ready}, 1);

    // Write with good ack, read, write with bad ack.
    txn(1'b1, 16'h1234, 8'hA5, 8'h5A, {1'b0, 8'h00});
    txn(1'b0, 16'hBEEF, 8'h00, 8'h3C, {1'b0, 8'h3C});
    txn(1'b1, 16'h00FF, 8'h11, 8'h00, {1'b1, 8'h00});

    // Long busy stall mid-frame with a stray rx byte while in SEND.
    n0 = n_resp;
    push_frame(1'b0, 16'h5500, 8'h00);
    exp_rsp.push_back({1'b0, 8'h42});
    send_req(1'b0, 16'h5500, 8'h00);
    wait_tx_left(3);
    busy_force = 1'b1;
    step(50);
    rx_pulse(8'h77);
    step(49);
    chk("stall_hold", exp_tx.size(), 3);
    busy_force = 1'b0;
    wait_tx_left(0);
    step(10);
    rx_pulse(8'h42);
    wait_resp(n0);

`ifdef UART_HOST_TIMEOUT_EN
    // No response byte: timeout after TMO cycles in WAIT_RSP.
    n0 = n_resp;
    push_frame(1'b0, 16'h0A0B, 8'h00);
    exp_rsp.push_back({1'b1, 8'h00});
    send_req(1'b0, 16'h0A0B, 8'h00);
    wait_tx_left(0);
    rsp_cyc_exp = last_strb + DRAIN_LAT + int'(TMO);
    wait_resp(n0);

    // Byte on the expiry cycle wins over the timeout.
    n0 = n_resp;
    push_frame(1'b0, 16'h0C0D, 8'h00);
    exp_rsp.push_back({1'b0, 8'h66});
    send_req(1'b0, 16'h0C0D, 8'h00);
    wait_tx_left(0);
    begin
      int tgt;
      tgt = last_strb + DRAIN_LAT + int'(TMO) - 1;
      for (int i = 0; i < 200 && cyc < tgt; i++) step(1);
      chk("exp_cyc_reach", cyc, tgt);
    end
    rx_pulse(8'h66);
    wait_resp(n0);
`endif

    // Reset after the 3rd frame byte: outputs drop at once, no further bytes.
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h10);
    exp_tx.push_back(8'hCA);
    send_req(1'b0, 16'hCAFE, 8'h00);
    wait_tx_left(0);
    reset = 1'b0;
    #1;
    chk_idle_outs("midrst");
    step(4);
    reset = 1'b1;
    step(2);
    txn(1'b0, 16'hCAFE, 8'h00, 8'h99, {1'b0, 8'h99});

    step(5);
    chk("tx_left", exp_tx.size(), 0);
    chk("rsp_left", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
